nandc_pagebuf_arb: RTL and testbench

Arbiter and burst sequencer for one port of the NAND page-buffer dual-port BRAM, with the other BRAM port reserved for the NAND bus engine. It shares that single port between the host-side requester (h_*) and the ECC/DMA requester (n_*) using round-robin arbitration. Each grant runs one linear burst: it generates addresses with wrap at DEPTH, moves write beats under a valid/ready handshake, and returns read data with the BRAM's 1-cycle latency.

---
 rtl/nandc_pagebuf_arb_if.sv | 29 ++
 rtl/nandc_pagebuf_arb.sv | 146 ++++++++++++++
 tb/tb_nandc_pagebuf_arb.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nandc_pagebuf_arb_if.sv
// Requester-side handshake bundle for one client of the page-buffer port arbiter.
// The requester drives the master modport; the arbiter uses the slave modport.
interface nandc_pagebuf_arb_if #(
  parameter int DATA = 32,
  parameter int ADDR = 10
);
  logic            req;
  logic            wr;
  logic [ADDR-1:0] addr;
  logic [ADDR-1:0] len;
  logic            gnt;
  logic [DATA-1:0] wdata;
  logic            wvalid;
  logic            wready;
  logic [DATA-1:0] rdata;
  logic            rvalid;
  logic            done;
  logic            err;

  modport master (
    output req, wr, addr, len, wdata, wvalid,
    input  gnt, wready, rdata, rvalid, done, err
  );

  modport slave (
    input  req, wr, addr, len, wdata, wvalid,
    output gnt, wready, rdata, rvalid, done, err
  );
endinterface

// File: rtl/nandc_pagebuf_arb.sv
// Round-robin arbiter and linear burst sequencer sharing one BRAM port between
// the host requester (h) and the ECC/DMA requester (n). Each grant runs one
// burst with address wrap at DEPTH; reads return data with 1-cycle latency.
module nandc_pagebuf_arb #(
  parameter int DATA  = 32,
  parameter int ADDR  = 10,
  parameter int DEPTH = 517
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nandc_pagebuf_arb_if.slave    h,
  nandc_pagebuf_arb_if.slave    n,
  output logic [ADDR-1:0]       mem_addr,
  output logic                  mem_wr,
  output logic [DATA-1:0]       mem_din,
  input  logic [DATA-1:0]       mem_dout
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
  localparam logic [ADDR-1:0] ONE       = ADDR'(1);

  typedef enum logic [1:0] {IDLE, BURST, RLAST, DONE} state_t;

  state_t          state;
  logic            last_n;    // 1: n was served last (also the current owner while granted)
  logic            wr_q;
  logic [ADDR-1:0] addr_cnt;
  logic [ADDR-1:0] beat_cnt;
  logic            gnt_q;
  logic            done_q;
  logic            err_q;
  logic            rvalid_q;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  logic            pick_n;
  logic            any_req;
  logic            st_wr;
  logic [ADDR-1:0] st_addr;
  logic [ADDR-1:0] st_len;
  logic            st_bad;

  assign any_req = h.req | n.req;
  assign pick_n  = n.req & (~h.req | ~last_n);
  assign st_wr   = pick_n ? n.wr   : h.wr;
  assign st_addr = pick_n ? n.addr : h.addr;
  assign st_len  = pick_n ? n.len  : h.len;
  assign st_bad  = st_addr > LAST_ADDR;

  // Burst datapath: the owner's write beat or a read issue advances the counters.
  logic            sel_wvalid;
  logic [DATA-1:0] sel_wdata;
  logic            burst_wr;
  logic            beat;
  logic            rd_issue;
  logic            advance;
  logic [ADDR-1:0] next_addr;

  assign sel_wvalid = last_n ? n.wvalid : h.wvalid;
  assign sel_wdata  = last_n ? n.wdata  : h.wdata;
  assign burst_wr   = (state == BURST) & wr_q;
  assign beat       = burst_wr & sel_wvalid;
  assign rd_issue   = (state == BURST) & ~wr_q;
  assign advance    = beat | rd_issue;
  assign next_addr  = (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + ONE;

  // Sequencer FSM with registered grant, completion, error and read-valid flags.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_n   <= 1'b1;
      wr_q     <= 1'b0;
      addr_cnt <= '0;
      beat_cnt <= '0;
      gnt_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_issue;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_n   <= pick_n;
            wr_q     <= st_wr;
            addr_cnt <= st_addr;
            beat_cnt <= st_len;
            gnt_q    <= 1'b1;
            if ((st_len == '0) || st_bad) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= st_bad;
            end else begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          if (advance) begin
            addr_cnt <= next_addr;
            beat_cnt <= beat_cnt - ONE;
            if (beat_cnt == ONE) begin
              if (wr_q) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state <= RLAST;
              end
            end
          end
        end
        RLAST: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          gnt_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // BRAM port: driven only during a granted read issue or write beat, else idle zeros.
  assign mem_addr = advance ? addr_cnt  : '0;
  assign mem_wr   = beat;
  assign mem_din  = beat    ? sel_wdata : '0;

  // Per-requester outputs: registered flags qualified by the current owner.
  assign h.gnt    = gnt_q    & ~last_n;
  assign n.gnt    = gnt_q    &  last_n;
  assign h.wready = burst_wr & ~last_n;
  assign n.wready = burst_wr &  last_n;
  assign h.rvalid = rvalid_q & ~last_n;
  assign n.rvalid = rvalid_q &  last_n;
  assign h.done   = done_q   & ~last_n;
  assign n.done   = done_q   &  last_n;
  assign h.err    = err_q    & ~last_n;
  assign n.err    = err_q    &  last_n;
  assign h.rdata  = mem_dout;
  assign n.rdata  = mem_dout;

endmodule

// File: tb/tb_nandc_pagebuf_arb.sv
// Directed bench for nandc_pagebuf_arb with a 1-cycle-latency BRAM model.
module tb_nandc_pagebuf_arb;
  localparam int DATA  = 32;
  localparam int ADDR  = 10;
  localparam int DEPTH = 517;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nandc_pagebuf_arb_if #(.DATA(DATA), .ADDR(ADDR)) h_if ();
  nandc_pagebuf_arb_if #(.DATA(DATA), .ADDR(ADDR)) n_if ();

  logic [ADDR-1:0] mem_addr;
  logic            mem_wr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout;
  logic [DATA-1:0] mem [DEPTH];

  nandc_pagebuf_arb #(.DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h        (h_if),
    .n        (n_if),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // BRAM model: write-first is irrelevant here; read data appears one cycle after address.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, 32'({h_if.gnt, n_if.gnt, h_if.done, n_if.done, h_if.err, n_if.err,
                                h_if.rvalid, n_if.rvalid, h_if.wready, n_if.wready, mem_wr}), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_din"}, mem_din, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   ph;
  logic own_n;
  int   waddr [4];
  int   rv_cnt, addr_err, data_err, done_at;

  initial begin
    waddr = '{515, 516, 0, 1};
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst_n = 1'b0;
    h_if.req = 0; h_if.wr = 0; h_if.addr = '0; h_if.len = '0; h_if.wdata = '0; h_if.wvalid = 0;
    n_if.req = 0; n_if.wr = 0; n_if.addr = '0; n_if.len = '0; n_if.wdata = '0; n_if.wvalid = 0;
    step(); step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();

    // Host read addr=5 len=4
    h_if.req = 1; h_if.wr = 0; h_if.addr = 10'd5; h_if.len = 10'd4;
    #1;
    check("t1_r_gnt", 32'(h_if.gnt), 32'd0);
    step();
    check("t1_g_gnt", 32'(h_if.gnt), 32'd1);
    check("t1_g_ngnt", 32'(n_if.gnt), 32'd0);
    check("t1_g_addr", 32'(mem_addr), 32'd5);
    check("t1_g_rvalid", 32'(h_if.rvalid), 32'd0);
    check("t1_g_wr", 32'(mem_wr), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t1_addr", 32'(mem_addr), 32'(5 + i));
      check("t1_rvalid", 32'(h_if.rvalid), 32'd1);
      check("t1_rdata", h_if.rdata, 32'hA000_0000 + 32'(4 + i));
      check("t1_nrvalid", 32'(n_if.rvalid), 32'd0);
    end
    step();
    check("t1_last_rvalid", 32'(h_if.rvalid), 32'd1);
    check("t1_last_rdata", h_if.rdata, 32'hA000_0008);
    check("t1_early_done", 32'(h_if.done), 32'd0);
    step();
    check("t1_done", 32'(h_if.done), 32'd1);
    check("t1_done_gnt", 32'(h_if.gnt), 32'd1);
    check("t1_done_rvalid", 32'(h_if.rvalid), 32'd0);
    check("t1_err", 32'(h_if.err), 32'd0);
    check("t1_ndone", 32'(n_if.done), 32'd0);
    h_if.req = 0;
    step();
    check("t1_gnt_fall", 32'(h_if.gnt), 32'd0);

    // Reset, then both request len=1 reads and hold: h,n,h,n
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    h_if.req = 1; h_if.wr = 0; h_if.addr = 10'd10; h_if.len = 10'd1;
    n_if.req = 1; n_if.wr = 0; n_if.addr = 10'd20; n_if.len = 10'd1;
    for (int c = 1; c <= 16; c++) begin
      step();
      ph    = (c - 1) % 4;
      own_n = (((c - 1) / 4) % 2) == 1;
      check("t2_hgnt", 32'(h_if.gnt), 32'((ph <= 2) && !own_n));
      check("t2_ngnt", 32'(n_if.gnt), 32'((ph <= 2) && own_n));
      check("t2_hdone", 32'(h_if.done), 32'((ph == 2) && !own_n));
      check("t2_ndone", 32'(n_if.done), 32'((ph == 2) && own_n));
      if (ph == 0) check("t2_addr", 32'(mem_addr), own_n ? 32'd20 : 32'd10);
      if (ph == 1) begin
        check("t2_hrvalid", 32'(h_if.rvalid), 32'(!own_n));
        check("t2_nrvalid", 32'(n_if.rvalid), 32'(own_n));
        check("t2_rdata", h_if.rdata, own_n ? 32'hA000_0014 : 32'hA000_000A);
      end
      if (c == 15) begin
        h_if.req = 0;
        n_if.req = 0;
      end
    end
    step();
    check("t2_idle", 32'({h_if.gnt, n_if.gnt}), 32'd0);

    // NAND write addr=515 len=4, wvalid low every other cycle
    n_if.req = 1; n_if.wr = 1; n_if.addr = 10'd515; n_if.len = 10'd4; n_if.wvalid = 0;
    step();
    for (int g = 0; g <= 6; g++) begin
      if (g > 0) step();
      n_if.wvalid = (g % 2) == 0;
      n_if.wdata  = 32'hC0DE_0000 + 32'(g / 2);
      #1;
      check("t3_nwready", 32'(n_if.wready), 32'd1);
      check("t3_hwready", 32'(h_if.wready), 32'd0);
      check("t3_memwr", 32'(mem_wr), 32'((g % 2) == 0));
      check("t3_ndone", 32'(n_if.done), 32'd0);
      if ((g % 2) == 0) begin
        check("t3_addr", 32'(mem_addr), 32'(waddr[g / 2]));
        check("t3_din", mem_din, 32'hC0DE_0000 + 32'(g / 2));
      end
    end
    step();
    n_if.wvalid = 0;
    #1;
    check("t3_done", 32'(n_if.done), 32'd1);
    check("t3_done_gnt", 32'(n_if.gnt), 32'd1);
    check("t3_err", 32'(n_if.err), 32'd0);
    check("t3_done_wr", 32'(mem_wr), 32'd0);
    n_if.req = 0; n_if.wr = 0;
    step();
    check("t3_gnt_fall", 32'(n_if.gnt), 32'd0);
    check("t3_m515", mem[515], 32'hC0DE_0000);
    check("t3_m516", mem[516], 32'hC0DE_0001);
    check("t3_m0", mem[0], 32'hC0DE_0002);
    check("t3_m1", mem[1], 32'hC0DE_0003);

    // Host write len=0 at legal address: done without err or access
    h_if.req = 1; h_if.wr = 1; h_if.addr = 10'd3; h_if.len = 10'd0;
    h_if.wvalid = 1; h_if.wdata = 32'hDEAD_BEEF;
    #1;
    check("t4a_r_wr", 32'(mem_wr), 32'd0);
    step();
    check("t4a_gnt", 32'(h_if.gnt), 32'd1);
    check("t4a_done", 32'(h_if.done), 32'd1);
    check("t4a_err", 32'(h_if.err), 32'd0);
    check("t4a_wr", 32'(mem_wr), 32'd0);
    check("t4a_wready", 32'(h_if.wready), 32'd0);
    h_if.req = 0; h_if.wvalid = 0;
    step();
    check("t4a_gnt_fall", 32'({h_if.gnt, h_if.done}), 32'd0);
    check("t4a_m3", mem[3], 32'hA000_0003);

    // NAND read at addr=600: done with err, no access
    n_if.req = 1; n_if.wr = 0; n_if.addr = 10'd600; n_if.len = 10'd4;
    step();
    check("t4b_gnt", 32'(n_if.gnt), 32'd1);
    check("t4b_done", 32'(n_if.done), 32'd1);
    check("t4b_err", 32'(n_if.err), 32'd1);
    check("t4b_herr", 32'(h_if.err), 32'd0);
    check("t4b_rvalid", 32'(n_if.rvalid), 32'd0);
    n_if.req = 0;
    step();
    check("t4b_after", 32'({n_if.gnt, n_if.rvalid, n_if.err, n_if.done}), 32'd0);

    // Host write addr=100 len=6, reset after 2 beats
    h_if.req = 1; h_if.wr = 1; h_if.addr = 10'd100; h_if.len = 10'd6;
    h_if.wvalid = 1; h_if.wdata = 32'hE000_0000;
    step();
    check("t5_b0_wr", 32'(mem_wr), 32'd1);
    check("t5_b0_addr", 32'(mem_addr), 32'd100);
    step();
    h_if.wdata = 32'hE000_0001;
    #1;
    check("t5_b1_addr", 32'(mem_addr), 32'd101);
    check("t5_b1_din", mem_din, 32'hE000_0001);
    step();
    h_if.wdata = 32'hE000_0002;
    #1;
    check("t5_b2_wr", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("t5_rst");
    h_if.wr = 0; h_if.len = 10'd1; h_if.wvalid = 0;
    n_if.req = 1; n_if.wr = 0; n_if.addr = 10'd200; n_if.len = 10'd1;
    step();
    check_quiet("t5_rst_hold");
    rst_n = 1'b1;
    step();
    check("t5_hgnt", 32'(h_if.gnt), 32'd1);
    check("t5_ngnt", 32'(n_if.gnt), 32'd0);
    check("t5_addr", 32'(mem_addr), 32'd100);
    step();
    check("t5_rvalid", 32'(h_if.rvalid), 32'd1);
    check("t5_rdata", h_if.rdata, 32'hE000_0000);
    step();
    check("t5_hdone", 32'(h_if.done), 32'd1);
    h_if.req = 0;
    step();
    check("t5_gap", 32'({h_if.gnt, n_if.gnt}), 32'd0);
    step();
    check("t5_ngnt2", 32'(n_if.gnt), 32'd1);
    check("t5_naddr", 32'(mem_addr), 32'd200);
    step();
    check("t5_nrdata", n_if.rdata, 32'hA000_00C8);
    step();
    check("t5_ndone", 32'(n_if.done), 32'd1);
    n_if.req = 0;
    check("t5_m101", mem[101], 32'hE000_0001);
    check("t5_m102", mem[102], 32'hA000_0066);
    step();

    // Host read len=600 from 0: wraps 516 -> 0, exactly 600 rvalid cycles
    h_if.req = 1; h_if.wr = 0; h_if.addr = 10'd0; h_if.len = 10'd600;
    step();
    rv_cnt = 0; addr_err = 0; data_err = 0; done_at = -1;
    for (int i = 0; i <= 603; i++) begin
      if (i > 0) step();
      if (i < 600 && int'(mem_addr) != (i % DEPTH)) addr_err++;
      if (i == 516) check("t6_addr516", 32'(mem_addr), 32'd516);
      if (i == 517) check("t6_wrap", 32'(mem_addr), 32'd0);
      if (h_if.rvalid) begin
        rv_cnt++;
        if (i == 0 || h_if.rdata !== mem[(i - 1) % DEPTH]) data_err++;
      end
      if (h_if.done && done_at < 0) begin
        done_at  = i;
        h_if.req = 0;
      end
    end
    check("t6_rvalid_cnt", 32'(rv_cnt), 32'd600);
    check("t6_addr_err", 32'(addr_err), 32'd0);
    check("t6_data_err", 32'(data_err), 32'd0);
    check("t6_done_at", 32'(done_at), 32'd601);
    check("t6_end", 32'(h_if.gnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
